// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 7-segment anode scan producer with frame-synchronous display update
//
// Purpose:
//   Scans four hex digits. A prescaler divides clk down to one digit slot every
//   CLK_DIV cycles, and a 2-bit refreshcounter walks the slots 0..3 to drive the
//   anode decoder. The display value is double-buffered: writes go into a pending
//   register and are copied to the display register only on the 3->0 wrap of the
//   scan, so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   rst            in   1   asynchronous active-high reset
//   data_in        in   16  new display value, digit 0 = least significant nibble
//   data_valid     in   1   one-cycle strobe that captures data_in into pending
//   upd_ack        out  1   one-cycle pulse when pending is committed to the display
//   refreshcounter out  2   active digit index, to the anode decoder
//   digit_val      out  4   display nibble selected by refreshcounter
//   digit_blank    out  1   1 = keep all cathodes of the current digit off
//   frame_tick     out  1   one-cycle pulse on the scan wrap 3->0

module display_scan_ctrl #(
  parameter int unsigned CLK_DIV  = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        upd_ack,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  digit_val,
  output logic        digit_blank,
  output logic        frame_tick
);

  localparam int unsigned    PW      = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0]  PS_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    rc_q, rc_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          upd_ack_q, upd_ack_d;
  logic          frame_tick_q, frame_tick_d;

  logic          slot_end;
  logic          commit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q  <= '0;
      rc_q         <= 2'd0;
      disp_q       <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      upd_ack_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      rc_q         <= rc_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      upd_ack_q    <= upd_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Next-state logic
  always_comb begin
    slot_end = (prescaler_q == PS_LAST);
    commit   = slot_end && (rc_q == 2'd3);

    prescaler_d = slot_end ? '0 : prescaler_q + PW'(1);
    rc_d        = slot_end ? rc_q + 2'd1 : rc_q;

    // The display always takes the value that was pending before this edge,
    // so a strobe landing on the commit edge is held for the next frame.
    disp_d = (commit && pend_valid_q) ? pend_q : disp_q;

    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (data_valid) begin
      pend_d       = data_in;
      pend_valid_d = 1'b1;
    end else if (commit) begin
      pend_valid_d = 1'b0;
    end

    upd_ack_d    = commit && pend_valid_q;
    frame_tick_d = commit;
  end

  // Output logic: only a mux and zero-compares on registered state
  always_comb begin
    digit_val   = 4'h0;
    digit_blank = 1'b0;
    case (rc_q)
      2'd0: digit_val = disp_q[3:0];
      2'd1: digit_val = disp_q[7:4];
      2'd2: digit_val = disp_q[11:8];
      default: digit_val = disp_q[15:12];
    endcase
    if (BLANK_LZ) begin
      // A digit is a leading zero when it and every more significant digit
      // are zero; digit 0 always stays lit so "0" is still shown.
      case (rc_q)
        2'd0: digit_blank = 1'b0;
        2'd1: digit_blank = (disp_q[15:4] == 12'h000);
        2'd2: digit_blank = (disp_q[15:8] == 8'h00);
        default: digit_blank = (disp_q[15:12] == 4'h0);
      endcase
    end
  end

  assign refreshcounter = rc_q;
  assign upd_ack        = upd_ack_q;
  assign frame_tick     = frame_tick_q;

endmodule
